vector_alu: RTL and testbench
=============================

// Module: vector_alu
// PURPOSE
//  Element-serial vector/scalar ALU, directly downstream of the register-read stage and fed by its alu_* issue outputs.
//  Processes one SEW-bit element per cycle across a VLEN-bit operand.
//  Returns the result to writeback and reports the scoreboard slot (pos) on completion.
// PARAMETERS
//  VLEN  128  vector register width (bits)
//  XLEN  32   scalar register width (bits)
//  SEW   32   element width (bits); NELEM = VLEN/SEW elements per op
// PORTS
//  clk          in   1             clock, rising edge
//  rst          in   1             asynchronous, active-high reset
//  in_valid     in   1             issue request from register-read stage
//  in_ready     out  1             ALU can accept an issue (comb: state==IDLE)
//  in_value1    in   VLEN          rs1 operand (vector, or scalar in [XLEN-1:0])
//  in_value2    in   VLEN          rs2 operand (vs2)
//  in_pos       in   `SB_SIZE_WID  scoreboard slot
//  in_opt       in   `OPT_WID      opcode class (captured, unused)
//  in_funct3    in   `FUNCT3_WID   000=VV, 100=VX, 011=VI
//  in_funct6    in   `FUNCT6_WID   operation select
//  in_rd        in   `REG_WID      destination; bit5=1 vector, bit5=0 scalar
//  in_imm       in   XLEN          immediate; [4:0] used for VI
//  wb_valid     out  1             one-cycle result pulse
//  wb_rd        out  `REG_WID      destination of result
//  wb_value     out  VLEN          result
//  done_pos     out  `SB_SIZE_WID  scoreboard slot being completed
//  illegal      out  1             with wb_valid: funct6/funct3 unsupported
// BEHAVIOUR
//  Reset (async): state=IDLE, idx=0, wb_valid=0, wb_rd=0, wb_value=0, done_pos=0, illegal=0, operand regs=0.
//  FSM IDLE->EXEC->DONE->IDLE. Issue accepted on the edge where in_valid && state==IDLE; all in_* captured.
//   in_valid while not IDLE is ignored; no buffering.
//  Operand a(k) = in_value1 element k (VV) | in_value1[SEW-1:0] broadcast (VX) | sext(in_imm[4:0]) (VI).
//   b(k) = in_value2 element k. Element k = bits [k*SEW +: SEW].
//  funct6: 000000 add b+a; 000010 sub b-a; 000100 minu; 000101 min(signed); 000110 maxu; 000111 max(signed);
//   001001 and; 001010 or; 001011 xor. Add/sub wrap modulo 2^SEW; no flags.
//  Unsupported funct6 or funct3: element result 0, illegal=1 at completion.
//  EXEC: one element per edge, idx 0..N-1; result element written to result reg; idx wraps to 0 on leaving EXEC.
//  N = NELEM if in_rd[5]=1. N = 1 if in_rd[5]=0 (scalar dest: element 0 only, wb_value[VLEN-1:XLEN]=0).
//  Last-element edge -> DONE; wb_valid=1, wb_value, wb_rd, done_pos, illegal valid for exactly that cycle.
//  Next edge: DONE->IDLE, wb_valid=0 (wb_rd/wb_value/done_pos hold last value).
//  Latency: accept edge E; wb_valid high after edge E+N; in_ready high again after E+N+1.
//   Back-to-back throughput: one op per N+2 cycles.
//  Result register cleared to 0 on accept; untouched elements read as 0.
//  Reset asserted mid-op: immediate abort, no wb_valid pulse, slot never reported.
// TESTING
//  VV add, NELEM=4, rd=6'h21, v2 elems {1,2,3,0xFFFFFFFF}, v1 elems {1,1,1,1} -> 4 edges after accept,
//   wb_value elems {2,3,4,0}, wb_valid 1 cycle, done_pos=in_pos.
//  VI sub, imm[4:0]=5'h1F (-1), v2 elems all 5 -> elems all 6; VX and with in_value1[31:0]=0x0F0F -> each elem masked.
//  min vs minu, b=0x80000000, a=1 -> min=0x80000000, minu=1.
//  Scalar dest rd=6'h05 VV add -> wb_valid 1 edge after accept, wb_value=elem0 sum, upper bits 0.
//  in_valid held high across op with second payload -> first completes unchanged;
//   second accepted only in first IDLE cycle, pos order preserved.
//  funct6=6'b111111 -> wb_value=0, illegal=1; rst pulsed 2 cycles into EXEC -> no wb_valid, in_ready=1 after reset.

Source files
------------

// File: rtl/vector_alu.sv
// Element-serial vector/scalar ALU fed by the register-read stage.
// One SEW-bit element per cycle; result and scoreboard slot to writeback.
`ifndef SB_SIZE_WID
`define SB_SIZE_WID 4
`endif
`ifndef OPT_WID
`define OPT_WID 7
`endif
`ifndef FUNCT3_WID
`define FUNCT3_WID 3
`endif
`ifndef FUNCT6_WID
`define FUNCT6_WID 6
`endif
`ifndef REG_WID
`define REG_WID 6
`endif

module vector_alu #(
  parameter int VLEN = 128,
  parameter int XLEN = 32,
  parameter int SEW  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [VLEN-1:0]         in_value1,
  input  logic [VLEN-1:0]         in_value2,
  input  logic [`SB_SIZE_WID-1:0] in_pos,
  input  logic [`OPT_WID-1:0]     in_opt,
  input  logic [`FUNCT3_WID-1:0]  in_funct3,
  input  logic [`FUNCT6_WID-1:0]  in_funct6,
  input  logic [`REG_WID-1:0]     in_rd,
  input  logic [XLEN-1:0]         in_imm,
  output logic                    wb_valid,
  output logic [`REG_WID-1:0]     wb_rd,
  output logic [VLEN-1:0]         wb_value,
  output logic [`SB_SIZE_WID-1:0] done_pos,
  output logic                    illegal
);

  localparam int NELEM = VLEN / SEW;
  localparam int IW    = $clog2(NELEM);
  localparam int SW    = $clog2(SEW);
  localparam int BW    = $clog2(VLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [IW-1:0]           r_idx;
  logic [VLEN-1:0]         r_v1;
  logic [VLEN-1:0]         r_v2;
  logic [VLEN-1:0]         r_res;
  logic [`SB_SIZE_WID-1:0] r_pos;
  logic [`OPT_WID-1:0]     r_opt;
  logic [`FUNCT3_WID-1:0]  r_funct3;
  logic [`FUNCT6_WID-1:0]  r_funct6;
  logic [`REG_WID-1:0]     r_rd;
  logic [XLEN-1:0]         r_imm;

  logic            w_accept;
  logic            w_last;
  logic [IW-1:0]   w_last_idx;
  logic [BW-1:0]   w_base;
  logic [SEW-1:0]  w_a;
  logic [SEW-1:0]  w_b;
  logic [SEW-1:0]  w_elem;
  logic            w_f3_bad;
  logic            w_f6_bad;
  logic [VLEN-1:0] w_res_nxt;
  logic            w_unused_ok;

  assign in_ready    = (r_state == S_IDLE);
  assign w_accept    = in_ready && in_valid;
  // Scalar destinations only ever produce element 0.
  assign w_last_idx  = r_rd[5] ? IW'(NELEM - 1) : '0;
  assign w_last      = (r_idx == w_last_idx);
  assign w_base      = {r_idx, {SW{1'b0}}};
  assign w_b         = r_v2[w_base +: SEW];
  assign w_unused_ok = ^{r_opt, r_imm[XLEN-1:5]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_EXEC;
      S_EXEC:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_a      = '0;
    w_f3_bad = 1'b0;
    unique case (r_funct3)
      3'b000:  w_a = r_v1[w_base +: SEW];
      3'b100:  w_a = r_v1[SEW-1:0];
      3'b011:  w_a = {{(SEW-5){r_imm[4]}}, r_imm[4:0]};
      default: w_f3_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_elem   = '0;
    w_f6_bad = 1'b0;
    unique case (r_funct6)
      6'b000000: w_elem = w_b + w_a;
      6'b000010: w_elem = w_b - w_a;
      6'b000100: w_elem = (w_b < w_a) ? w_b : w_a;
      6'b000101: w_elem = ($signed(w_b) < $signed(w_a)) ? w_b : w_a;
      6'b000110: w_elem = (w_b > w_a) ? w_b : w_a;
      6'b000111: w_elem = ($signed(w_b) > $signed(w_a)) ? w_b : w_a;
      6'b001001: w_elem = w_b & w_a;
      6'b001010: w_elem = w_b | w_a;
      6'b001011: w_elem = w_b ^ w_a;
      default:   w_f6_bad = 1'b1;
    endcase
    if (w_f3_bad) w_elem = '0;
  end

  always_comb begin
    w_res_nxt = r_res;
    w_res_nxt[w_base +: SEW] = w_elem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx    <= '0;
      r_v1     <= '0;
      r_v2     <= '0;
      r_res    <= '0;
      r_pos    <= '0;
      r_opt    <= '0;
      r_funct3 <= '0;
      r_funct6 <= '0;
      r_rd     <= '0;
      r_imm    <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_value <= '0;
      done_pos <= '0;
      illegal  <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (w_accept) begin
        r_idx    <= '0;
        r_res    <= '0;
        r_v1     <= in_value1;
        r_v2     <= in_value2;
        r_pos    <= in_pos;
        r_opt    <= in_opt;
        r_funct3 <= in_funct3;
        r_funct6 <= in_funct6;
        r_rd     <= in_rd;
        r_imm    <= in_imm;
      end else if (r_state == S_EXEC) begin
        r_res <= w_res_nxt;
        if (w_last) begin
          r_idx    <= '0;
          wb_valid <= 1'b1;
          wb_value <= w_res_nxt;
          wb_rd    <= r_rd;
          done_pos <= r_pos;
          illegal  <= w_f3_bad | w_f6_bad;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_alu.sv
// Directed bench for vector_alu: vector table plus hand-written
// sequences for held in_valid and mid-op reset.
module tb_vector_alu;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_value1;
  logic [127:0] in_value2;
  logic [3:0]   in_pos;
  logic [6:0]   in_opt;
  logic [2:0]   in_funct3;
  logic [5:0]   in_funct6;
  logic [5:0]   in_rd;
  logic [31:0]  in_imm;
  logic         wb_valid;
  logic [5:0]   wb_rd;
  logic [127:0] wb_value;
  logic [3:0]   done_pos;
  logic         illegal;

  int n_pass = 0;
  int n_total = 0;

  vector_alu dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value1 (in_value1),
    .in_value2 (in_value2),
    .in_pos    (in_pos),
    .in_opt    (in_opt),
    .in_funct3 (in_funct3),
    .in_funct6 (in_funct6),
    .in_rd     (in_rd),
    .in_imm    (in_imm),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_value  (wb_value),
    .done_pos  (done_pos),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   f3;
    logic [5:0]   f6;
    logic [5:0]   rd;
    logic [127:0] v1;
    logic [127:0] v2;
    logic [31:0]  imm;
    logic [3:0]   pos;
    logic [127:0] exp;
    logic         exp_ill;
    int           lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    else
      n_pass++;
  endtask

  task automatic drive(input vec_t v);
    in_funct3 = v.f3;
    in_funct6 = v.f6;
    in_rd     = v.rd;
    in_value1 = v.v1;
    in_value2 = v.v2;
    in_imm    = v.imm;
    in_pos    = v.pos;
    in_opt    = 7'h57;
  endtask

  task automatic wait_wb(output int cyc);
    cyc = 0;
    while (cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (wb_valid) break;
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int cyc;
    @(negedge clk);
    chk($sformatf("v%0d_ready", id), 128'(in_ready), 128'd1);
    drive(v);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk($sformatf("v%0d_busy", id), 128'(in_ready), 128'd0);
    wait_wb(cyc);
    chk($sformatf("v%0d_latency", id), 128'(cyc), 128'(v.lat));
    chk($sformatf("v%0d_value", id), wb_value, v.exp);
    chk($sformatf("v%0d_rd", id), 128'(wb_rd), 128'(v.rd));
    chk($sformatf("v%0d_pos", id), 128'(done_pos), 128'(v.pos));
    chk($sformatf("v%0d_illegal", id), 128'(illegal), 128'(v.exp_ill));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_pulse", id), 128'(wb_valid), 128'd0);
    chk($sformatf("v%0d_ready_after", id), 128'(in_ready), 128'd1);
    chk($sformatf("v%0d_hold", id), wb_value, v.exp);
  endtask

  function automatic vec_t mk(input logic [2:0] f3, input logic [5:0] f6,
      input logic [5:0] rd, input logic [127:0] v1, input logic [127:0] v2,
      input logic [31:0] imm, input logic [3:0] pos, input logic [127:0] exp,
      input logic ill, input int lat);
    vec_t v;
    v.f3 = f3; v.f6 = f6; v.rd = rd; v.v1 = v1; v.v2 = v2;
    v.imm = imm; v.pos = pos; v.exp = exp; v.exp_ill = ill; v.lat = lat;
    return v;
  endfunction

  initial begin
    int   cyc;
    logic seen;
    vec_t va;
    vec_t vb;

    vecs[0] = mk(3'b000, 6'b000000, 6'h21,
      {32'd1, 32'd1, 32'd1, 32'd1},
      {32'hFFFFFFFF, 32'd3, 32'd2, 32'd1}, 32'd0, 4'd3,
      {32'd0, 32'd4, 32'd3, 32'd2}, 1'b0, 4);
    vecs[1] = mk(3'b011, 6'b000010, 6'h22, 128'hDEAD,
      {32'd5, 32'd5, 32'd5, 32'd5}, 32'h0000001F, 4'd4,
      {32'd6, 32'd6, 32'd6, 32'd6}, 1'b0, 4);
    vecs[2] = mk(3'b100, 6'b001001, 6'h23,
      {32'hDEADBEEF, 32'hCAFEBABE, 32'h12345678, 32'h00000F0F},
      {32'hF0F0F0F0, 32'h0, 32'h12345678, 32'hFFFFFFFF}, 32'd0, 4'd5,
      {32'h0, 32'h0, 32'h00000608, 32'h00000F0F}, 1'b0, 4);
    vecs[3] = mk(3'b000, 6'b000101, 6'h24,
      {32'd7, 32'd1, 32'd3, 32'd1},
      {32'd7, 32'hFFFFFFFF, 32'd5, 32'h80000000}, 32'd0, 4'd6,
      {32'd7, 32'hFFFFFFFF, 32'd3, 32'h80000000}, 1'b0, 4);
    vecs[4] = mk(3'b000, 6'b000100, 6'h25,
      {32'd7, 32'd1, 32'd3, 32'd1},
      {32'd7, 32'hFFFFFFFF, 32'd5, 32'h80000000}, 32'd0, 4'd7,
      {32'd7, 32'd1, 32'd3, 32'd1}, 1'b0, 4);
    vecs[5] = mk(3'b000, 6'b000110, 6'h26,
      {32'd7, 32'd1, 32'd3, 32'd1},
      {32'd7, 32'hFFFFFFFF, 32'd5, 32'h80000000}, 32'd0, 4'd8,
      {32'd7, 32'hFFFFFFFF, 32'd5, 32'h80000000}, 1'b0, 4);
    vecs[6] = mk(3'b000, 6'b000111, 6'h27,
      {32'd7, 32'd1, 32'd3, 32'd1},
      {32'd7, 32'hFFFFFFFF, 32'd5, 32'h80000000}, 32'd0, 4'd9,
      {32'd7, 32'd1, 32'd5, 32'd1}, 1'b0, 4);
    vecs[7] = mk(3'b000, 6'b001010, 6'h28,
      {32'h0000FF00, 32'h1, 32'h0, 32'hF0},
      {32'h00FF0000, 32'h2, 32'h0, 32'h0F}, 32'd0, 4'd10,
      {32'h00FFFF00, 32'h3, 32'h0, 32'hFF}, 1'b0, 4);
    vecs[8] = mk(3'b000, 6'b001011, 6'h29,
      {32'hFFFFFFFF, 32'hAAAA5555, 32'h0, 32'h1234},
      {32'hFFFFFFFF, 32'h5555AAAA, 32'h7, 32'h1234}, 32'd0, 4'd11,
      {32'h0, 32'hFFFFFFFF, 32'h7, 32'h0}, 1'b0, 4);
    vecs[9] = mk(3'b000, 6'b000000, 6'h05,
      {32'd9, 32'd9, 32'd9, 32'd10},
      {32'd9, 32'd9, 32'd9, 32'd20}, 32'd0, 4'd12,
      {96'd0, 32'd30}, 1'b0, 1);
    vecs[10] = mk(3'b000, 6'b111111, 6'h2A,
      {32'd1, 32'd2, 32'd3, 32'd4},
      {32'd5, 32'd6, 32'd7, 32'd8}, 32'd0, 4'd13,
      128'd0, 1'b1, 4);
    vecs[11] = mk(3'b001, 6'b000000, 6'h2B,
      {32'd1, 32'd2, 32'd3, 32'd4},
      {32'd5, 32'd6, 32'd7, 32'd8}, 32'd0, 4'd14,
      128'd0, 1'b1, 4);
    vecs[12] = mk(3'b000, 6'b000010, 6'h2C,
      {32'd0, 32'd5, 32'd1, 32'd2},
      {32'd0, 32'd3, 32'd1, 32'd1}, 32'd0, 4'd15,
      {32'd0, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFFF}, 1'b0, 4);

    rst = 1'b1;
    in_valid = 1'b0;
    drive(vecs[0]);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 128'(in_ready), 128'd1);
    chk("rst_wb_valid", 128'(wb_valid), 128'd0);
    chk("rst_wb_value", wb_value, 128'd0);
    chk("rst_wb_rd", 128'(wb_rd), 128'd0);
    chk("rst_done_pos", 128'(done_pos), 128'd0);
    chk("rst_illegal", 128'(illegal), 128'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // in_valid held high across an op with a second payload behind it
    va = mk(3'b000, 6'b000000, 6'h31,
      {32'd1, 32'd1, 32'd1, 32'd1},
      {32'd4, 32'd3, 32'd2, 32'd1}, 32'd0, 4'd1,
      {32'd5, 32'd4, 32'd3, 32'd2}, 1'b0, 4);
    vb = mk(3'b000, 6'b001011, 6'h32,
      {32'hFF, 32'hF0, 32'h0F, 32'hAA},
      {32'h0F, 32'h0F, 32'h0F, 32'h55}, 32'd0, 4'd2,
      {32'hF0, 32'hFF, 32'h00, 32'hFF}, 1'b0, 4);
    @(negedge clk);
    drive(va);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    drive(vb);
    wait_wb(cyc);
    chk("held_a_latency", 128'(cyc), 128'd4);
    chk("held_a_value", wb_value, va.exp);
    chk("held_a_pos", 128'(done_pos), 128'd1);
    @(posedge clk);
    #1;
    chk("held_idle", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    chk("held_b_accept", 128'(in_ready), 128'd0);
    in_valid = 1'b0;
    wait_wb(cyc);
    chk("held_b_latency", 128'(cyc), 128'd4);
    chk("held_b_value", wb_value, vb.exp);
    chk("held_b_pos", 128'(done_pos), 128'd2);
    chk("held_b_rd", 128'(wb_rd), 128'h32);
    @(posedge clk);
    #1;
    chk("held_end_ready", 128'(in_ready), 128'd1);

    // reset pulsed while the op is in EXEC
    va.pos = 4'd7;
    @(negedge clk);
    drive(va);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_ready", 128'(in_ready), 128'd1);
    chk("abort_wb_valid", 128'(wb_valid), 128'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      seen |= wb_valid;
    end
    chk("abort_no_wb", 128'(seen), 128'd0);
    chk("abort_ready_after", 128'(in_ready), 128'd1);
    chk("abort_done_pos", 128'(done_pos), 128'd0);
    chk("abort_wb_value", wb_value, 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout pass=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
